chip8_timer_sched: RTL

Controller that runs the CHIP-8 delay timer (DT) and sound timer (ST) at the 60 Hz tick rate. It issues read-modify-write sequences through the processor-class request port of `chip8_memory`. It sits beside the CPU core, shares that port through the core's request mux, and drives the beeper enable. Decrements saturate at zero, and ticks that arrive while a sequence is in flight are coalesced.

---
 rtl/chip8_timer_sched.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/chip8_timer_sched.sv
// CHIP-8 delay/sound timer scheduler: 60 Hz tick drives DT/ST decrement sequences over the processor request port.
// Optional sound-timer phase compiled in with CHIP8_SOUND_TIMER_EN.
module chip8_timer_sched #(
  parameter int unsigned TICK_PERIOD = 1_237_500,
  parameter int unsigned DT_ADDR     = 21,
  parameter int unsigned ST_ADDR     = 22
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        enable_in,
  output logic [11:0] mem_addr_out,
  output logic [1:0]  mem_type_out,
  output logic        mem_we_out,
  output logic [7:0]  mem_data_out,
  output logic        mem_valid_out,
  input  logic        mem_ready_in,
  input  logic        mem_rvalid_in,
  input  logic [7:0]  mem_data_in,
  output logic        busy_out,
  output logic        tick_out,
  output logic        overrun_out,
  output logic        sound_out
);

  localparam int unsigned CNT_W  = 32;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 8;
  localparam logic [1:0]       PROC_MEM_TYPE_REG = 2'd1;
  localparam logic [CNT_W-1:0] RELOAD            = CNT_W'(TICK_PERIOD - 1);

`ifdef CHIP8_SOUND_TIMER_EN
  typedef enum logic [3:0] {
    IDLE, DT_RD, DT_RD_WAIT, DT_WR, DT_WR_WAIT, ST_RD, ST_RD_WAIT, ST_WR, ST_WR_WAIT
  } state_t;
`else
  typedef enum logic [3:0] {
    IDLE, DT_RD, DT_RD_WAIT, DT_WR, DT_WR_WAIT
  } state_t;
`endif

  state_t           state;
  logic [CNT_W-1:0] tick_cnt;
  logic             tick_pending;
  logic             tick_raise;

  function automatic logic [ADDR_W-1:0] req_addr(input logic st);
    return st ? ADDR_W'(ST_ADDR) : ADDR_W'(DT_ADDR);
  endfunction

  assign tick_raise = enable_in && (tick_cnt == '0);
  assign busy_out   = (state != IDLE);

  // Tick generation, pending/overrun tracking and the read-modify-write sequencer
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state         <= IDLE;
      tick_cnt      <= RELOAD;
      tick_pending  <= 1'b0;
      tick_out      <= 1'b0;
      overrun_out   <= 1'b0;
      sound_out     <= 1'b0;
      mem_valid_out <= 1'b0;
      mem_we_out    <= 1'b0;
      mem_addr_out  <= '0;
      mem_data_out  <= '0;
      mem_type_out  <= '0;
    end else begin
      tick_out     <= 1'b0;
      mem_type_out <= PROC_MEM_TYPE_REG;

      if (tick_raise) begin
        tick_cnt <= RELOAD;
        tick_out <= 1'b1;
        if (tick_pending) overrun_out <= 1'b1;
      end else if (enable_in) begin
        tick_cnt <= tick_cnt - CNT_W'(1);
      end

      // A tick raised in the same cycle as the IDLE exit keeps pending set
      if (tick_raise) begin
        tick_pending <= 1'b1;
      end else if (state == IDLE && tick_pending) begin
        tick_pending <= 1'b0;
      end

`ifndef CHIP8_SOUND_TIMER_EN
      sound_out <= 1'b0;
`endif

      case (state)
        IDLE: begin
          if (tick_pending) begin
            state         <= DT_RD;
            mem_valid_out <= 1'b1;
            mem_we_out    <= 1'b0;
            mem_addr_out  <= req_addr(1'b0);
          end
        end
        DT_RD: begin
          if (mem_ready_in) begin
            state         <= DT_RD_WAIT;
            mem_valid_out <= 1'b0;
          end
        end
        DT_RD_WAIT: begin
          if (mem_rvalid_in) begin
            if (mem_data_in != '0) begin
              state         <= DT_WR;
              mem_valid_out <= 1'b1;
              mem_we_out    <= 1'b1;
              mem_addr_out  <= req_addr(1'b0);
              mem_data_out  <= mem_data_in - DATA_W'(1);
            end else begin
`ifdef CHIP8_SOUND_TIMER_EN
              state         <= ST_RD;
              mem_valid_out <= 1'b1;
              mem_we_out    <= 1'b0;
              mem_addr_out  <= req_addr(1'b1);
`else
              state         <= IDLE;
`endif
            end
          end
        end
        DT_WR: begin
          if (mem_ready_in) begin
            state         <= DT_WR_WAIT;
            mem_valid_out <= 1'b0;
          end
        end
        DT_WR_WAIT: begin
          if (mem_rvalid_in) begin
`ifdef CHIP8_SOUND_TIMER_EN
            state         <= ST_RD;
            mem_valid_out <= 1'b1;
            mem_we_out    <= 1'b0;
            mem_addr_out  <= req_addr(1'b1);
`else
            state         <= IDLE;
`endif
          end
        end
`ifdef CHIP8_SOUND_TIMER_EN
        ST_RD: begin
          if (mem_ready_in) begin
            state         <= ST_RD_WAIT;
            mem_valid_out <= 1'b0;
          end
        end
        ST_RD_WAIT: begin
          if (mem_rvalid_in) begin
            sound_out <= (mem_data_in != '0);
            if (mem_data_in != '0) begin
              state         <= ST_WR;
              mem_valid_out <= 1'b1;
              mem_we_out    <= 1'b1;
              mem_addr_out  <= req_addr(1'b1);
              mem_data_out  <= mem_data_in - DATA_W'(1);
            end else begin
              state <= IDLE;
            end
          end
        end
        ST_WR: begin
          if (mem_ready_in) begin
            state         <= ST_WR_WAIT;
            mem_valid_out <= 1'b0;
          end
        end
        ST_WR_WAIT: begin
          if (mem_rvalid_in) state <= IDLE;
        end
`endif
        default: begin
          state         <= IDLE;
          mem_valid_out <= 1'b0;
        end
      endcase
    end
  end

endmodule
